// File: rtl/processor_stage2_if.sv
// Opcode constants shared across the pipeline, and the stage-2 port bundle.
// The master side is the surrounding pipeline; stage 2 itself uses the slave side.
package processor_stage2_pkg;
  localparam logic [3:0] OP_NOP              = 4'd0;
  localparam logic [3:0] OP_REG_MOV          = 4'd1;
  localparam logic [3:0] OP_REG_ADD          = 4'd2;
  localparam logic [3:0] OP_REG_ADD_IMM8     = 4'd3;
  localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'd4;
  localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'd5;
  localparam logic [3:0] OP_CALL             = 4'd6;
  localparam logic [3:0] OP_RETURN           = 4'd7;
  localparam logic [3:0] OP_WAIT             = 4'd8;
  localparam logic [3:0] OP_JUMP             = 4'd9;
endpackage

interface processor_stage2_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_code_word;
  logic [ADDR_SIZE-1:0] in_ip;
  logic                 stall;
  logic [2:0]           reg_read_addr0;
  logic [2:0]           reg_read_addr1;
  logic [WORD_SIZE-1:0] reg_read_data0;
  logic [WORD_SIZE-1:0] reg_read_data1;
  logic                 wb_enable;
  logic [2:0]           wb_addr;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 flush;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_write_enable;
  logic [WORD_SIZE-1:0] mem_write_data;
  logic                 no_operation;
  logic [WORD_SIZE-1:0] alu_data0;
  logic [WORD_SIZE-1:0] alu_data1;
  logic [WORD_SIZE-1:0] data1_plus_imm8;
  logic [WORD_SIZE-1:0] code_word;
  logic [ADDR_SIZE-1:0] ip;
  logic [ADDR_SIZE-1:0] ip_plus_one;

  modport slave (
    input  in_valid, in_code_word, in_ip, reg_read_data0, reg_read_data1,
           wb_enable, wb_addr, wb_data, flush,
    output stall, reg_read_addr0, reg_read_addr1, mem_addr, mem_write_enable,
           mem_write_data, no_operation, alu_data0, alu_data1, data1_plus_imm8,
           code_word, ip, ip_plus_one
  );

  modport master (
    output in_valid, in_code_word, in_ip, reg_read_data0, reg_read_data1,
           wb_enable, wb_addr, wb_data, flush,
    input  stall, reg_read_addr0, reg_read_addr1, mem_addr, mem_write_enable,
           mem_write_data, no_operation, alu_data0, alu_data1, data1_plus_imm8,
           code_word, ip, ip_plus_one
  );
endinterface

// File: rtl/processor_stage2.sv
// Decode/operand-fetch stage: forwards stage-3 writeback, issues data-memory access,
// registers operands for stage 3 one cycle later; stalls stage 1 only while in OP_WAIT.
module processor_stage2
  import processor_stage2_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic              clock,
  input  logic              reset,
  processor_stage2_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_KILL} state_t;

  state_t               state_q, state_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic                 no_operation_q, no_operation_d;
  logic [WORD_SIZE-1:0] alu_data0_q, alu_data0_d;
  logic [WORD_SIZE-1:0] alu_data1_q, alu_data1_d;
  logic [WORD_SIZE-1:0] data1_plus_imm8_q, data1_plus_imm8_d;
  logic [WORD_SIZE-1:0] code_word_q, code_word_d;
  logic [ADDR_SIZE-1:0] ip_q, ip_d;
  logic [ADDR_SIZE-1:0] ip_plus_one_q, ip_plus_one_d;

  logic [3:0]           op;
  logic [2:0]           rx, ry;
  logic [7:0]           imm8;
  logic [WORD_SIZE-1:0] imm_sext;
  logic [WORD_SIZE-1:0] fwd0, fwd1, addr;
  logic                 accept;

  assign op       = bus.in_code_word[17:14];
  assign rx       = bus.in_code_word[13:11];
  assign ry       = bus.in_code_word[10:8];
  assign imm8     = bus.in_code_word[7:0];
  assign imm_sext = {{(WORD_SIZE-8){imm8[7]}}, imm8};

  assign fwd0 = (bus.wb_enable && bus.wb_addr == rx) ? bus.wb_data : bus.reg_read_data0;
  assign fwd1 = (bus.wb_enable && bus.wb_addr == ry) ? bus.wb_data : bus.reg_read_data1;
  assign addr = fwd1 + imm_sext;

  // flush already excludes accept, so a store can never issue alongside a kill.
  assign accept = bus.in_valid && (state_q == ST_RUN) && !bus.flush;

  assign bus.reg_read_addr0   = rx;
  assign bus.reg_read_addr1   = ry;
  assign bus.mem_addr         = addr[ADDR_SIZE-1:0];
  assign bus.mem_write_data   = fwd0;
  assign bus.mem_write_enable = accept && (op == OP_WRITE_TO_MEMORY) && !reset;
  assign bus.stall            = (state_q == ST_WAIT) && !reset;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_KILL;
        end else if (accept && op == OP_WAIT && imm8 != 8'd0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = imm8;
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_d    = ST_KILL;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
          if (wait_cnt_q <= 8'd1) begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
          end
        end
      end
      ST_KILL: state_d = bus.flush ? ST_KILL : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    no_operation_d    = !accept;
    alu_data0_d       = alu_data0_q;
    alu_data1_d       = alu_data1_q;
    data1_plus_imm8_d = data1_plus_imm8_q;
    code_word_d       = code_word_q;
    ip_d              = ip_q;
    ip_plus_one_d     = ip_plus_one_q;
    if (accept) begin
      alu_data0_d       = fwd0;
      alu_data1_d       = fwd1;
      data1_plus_imm8_d = addr;
      code_word_d       = bus.in_code_word;
      ip_d              = bus.in_ip;
      ip_plus_one_d     = bus.in_ip + ADDR_SIZE'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_RUN;
      wait_cnt_q        <= 8'd0;
      no_operation_q    <= 1'b1;
      alu_data0_q       <= '0;
      alu_data1_q       <= '0;
      data1_plus_imm8_q <= '0;
      code_word_q       <= '0;
      ip_q              <= '0;
      ip_plus_one_q     <= '0;
    end else begin
      state_q           <= state_d;
      wait_cnt_q        <= wait_cnt_d;
      no_operation_q    <= no_operation_d;
      alu_data0_q       <= alu_data0_d;
      alu_data1_q       <= alu_data1_d;
      data1_plus_imm8_q <= data1_plus_imm8_d;
      code_word_q       <= code_word_d;
      ip_q              <= ip_d;
      ip_plus_one_q     <= ip_plus_one_d;
    end
  end

  assign bus.no_operation    = no_operation_q;
  assign bus.alu_data0       = alu_data0_q;
  assign bus.alu_data1       = alu_data1_q;
  assign bus.data1_plus_imm8 = data1_plus_imm8_q;
  assign bus.code_word       = code_word_q;
  assign bus.ip              = ip_q;
  assign bus.ip_plus_one     = ip_plus_one_q;

endmodule

// File: tb/tb_processor_stage2.sv
// Randomised bench for processor_stage2: a reference model predicts each accepted word,
// a monitor pops predictions whenever stage 2 presents a word to stage 3.
module tb_processor_stage2;
  import processor_stage2_pkg::*;

  localparam int AW = 18;
  localparam int WW = 18;

  typedef struct packed {
    logic [WW-1:0] code;
    logic [AW-1:0] ip;
    logic [AW-1:0] ipp1;
    logic [WW-1:0] d0;
    logic [WW-1:0] d1;
    logic [WW-1:0] sum;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  processor_stage2_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus ();
  processor_stage2 #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [WW-1:0] rf [8];
  assign bus.reg_read_data0 = rf[bus.reg_read_addr0];
  assign bus.reg_read_data1 = rf[bus.reg_read_addr1];

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   wait_left = 0;
  int   kill_left = 0;
  bit   prev_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stage-1/stage-3 activity; entered and left at posedge+1.
  task automatic step(input bit v, input logic [17:0] w, input logic [17:0] a, input bit fl,
                      input bit we, input logic [2:0] wa, input logic [17:0] wd);
    logic [17:0] f0, f1, sum;
    logic [3:0]  op;
    int          imm;
    bit          acc;
    exp_t        e;
    bus.in_valid = v; bus.in_code_word = w; bus.in_ip = a; bus.flush = fl;
    bus.wb_enable = we; bus.wb_addr = wa; bus.wb_data = wd;
    @(negedge clock);
    op  = w[17:14];
    f0  = (we && wa == w[13:11]) ? wd : rf[w[13:11]];
    f1  = (we && wa == w[10:8]) ? wd : rf[w[10:8]];
    imm = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
    sum = 18'(int'(f1) + 262144 + imm);
    acc = v && wait_left == 0 && kill_left == 0 && !fl;
    chk("stall", bus.stall, wait_left > 0);
    chk("no_operation", bus.no_operation, !prev_acc);
    if (v) begin
      chk("reg_read_addr0", bus.reg_read_addr0, w[13:11]);
      chk("reg_read_addr1", bus.reg_read_addr1, w[10:8]);
    end
    chk("mem_write_enable", bus.mem_write_enable, acc && op == OP_WRITE_TO_MEMORY);
    if (acc && (op == OP_LOAD_FROM_MEMORY || op == OP_WRITE_TO_MEMORY || op == OP_RETURN))
      chk("mem_addr", bus.mem_addr, sum);
    if (acc && op == OP_WRITE_TO_MEMORY)
      chk("mem_write_data", bus.mem_write_data, f0);
    if (acc) begin
      e.code = w; e.ip = a; e.ipp1 = a + 18'd1; e.d0 = f0; e.d1 = f1; e.sum = sum;
      sb.push_back(e);
    end
    prev_acc = acc;
    if (fl) begin
      wait_left = 0;
      kill_left = 1;
    end else if (kill_left > 0) begin
      kill_left = 0;
    end else if (wait_left > 0) begin
      wait_left--;
    end else if (acc && op == OP_WAIT) begin
      wait_left = int'(w[7:0]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (reset === 1'b0 && bus.no_operation === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got output code %0h expected no output", bus.code_word);
        end else begin
          e = sb.pop_front();
          chk("sb_code_word", bus.code_word, e.code);
          chk("sb_ip", bus.ip, e.ip);
          chk("sb_ip_plus_one", bus.ip_plus_one, e.ipp1);
          chk("sb_alu_data0", bus.alu_data0, e.d0);
          chk("sb_alu_data1", bus.alu_data1, e.d1);
          chk("sb_data1_plus_imm8", bus.data1_plus_imm8, e.sum);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0]  ops [6];
    logic [17:0] cur_w, cur_ip, w2;
    bit          have;
    ops[0] = OP_REG_ADD;  ops[1] = OP_REG_ADD_IMM8;     ops[2] = OP_LOAD_FROM_MEMORY;
    ops[3] = OP_RETURN;   ops[4] = OP_WRITE_TO_MEMORY;  ops[5] = OP_WAIT;
    for (int i = 0; i < 8; i++) rf[i] = 18'($urandom);
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_code_word = '0; bus.in_ip = '0; bus.flush = 1'b0;
    bus.wb_enable = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_no_operation", bus.no_operation, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_write_enable", bus.mem_write_enable, 0);
    chk("rst_alu_data0", bus.alu_data0, 0);
    chk("rst_data1_plus_imm8", bus.data1_plus_imm8, 0);
    chk("rst_ip_plus_one", bus.ip_plus_one, 0);
    reset = 1'b0;

    // r2 + sext(0xFE) = 10 - 2
    rf[2] = 18'd10;
    step(1, {OP_REG_ADD_IMM8, 3'd1, 3'd2, 8'hFE}, 18'h00123, 0, 0, 3'd0, 18'd0);
    chk("addimm_sum", bus.data1_plus_imm8, 18'd8);
    chk("addimm_ip_plus_one", bus.ip_plus_one, 18'h00124);

    rf[2] = 18'd5;
    step(1, {OP_LOAD_FROM_MEMORY, 3'd1, 3'd2, 8'h03}, 18'h00200, 0, 1, 3'd2, 18'h100);
    chk("fwd_alu_data1", bus.alu_data1, 18'h100);
    chk("fwd_sum", bus.data1_plus_imm8, 18'h103);

    rf[3] = 18'h2AAAA; rf[4] = 18'h50;
    step(1, {OP_WRITE_TO_MEMORY, 3'd3, 3'd4, 8'h00}, 18'h00300, 0, 0, 3'd0, 18'd0);
    step(0, 18'd0, 18'd0, 0, 0, 3'd0, 18'd0);

    step(1, {OP_WAIT, 3'd0, 3'd0, 8'd3}, 18'h00400, 0, 0, 3'd0, 18'd0);
    w2 = {OP_REG_ADD, 3'd5, 3'd6, 8'h11};
    for (int i = 0; i < 4; i++) step(1, w2, 18'h00401, 0, 0, 3'd0, 18'd0);
    step(1, {OP_WAIT, 3'd0, 3'd0, 8'd0}, 18'h00500, 0, 0, 3'd0, 18'd0);
    step(1, w2, 18'h00501, 0, 0, 3'd0, 18'd0);

    step(1, {OP_WRITE_TO_MEMORY, 3'd3, 3'd4, 8'h01}, 18'h00600, 1, 0, 3'd0, 18'd0);
    step(1, w2, 18'h00601, 0, 0, 3'd0, 18'd0);
    step(1, w2, 18'h00602, 0, 0, 3'd0, 18'd0);
    chk("flush_third_ip", bus.ip, 18'h00602);

    step(1, {OP_REG_ADD_IMM8, 3'd1, 3'd2, 8'h01}, 18'h3FFFF, 0, 0, 3'd0, 18'd0);
    chk("wrap_ip_plus_one", bus.ip_plus_one, 18'd0);

    step(1, {OP_WAIT, 3'd0, 3'd0, 8'd5}, 18'h00700, 0, 0, 3'd0, 18'd0);
    step(1, w2, 18'h00701, 0, 0, 3'd0, 18'd0);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("stall_during_reset", bus.stall, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_left = 0; kill_left = 0; prev_acc = 1'b0;
    chk("after_reset_stall", bus.stall, 0);
    chk("after_reset_no_operation", bus.no_operation, 1);
    step(1, w2, 18'h00701, 0, 0, 3'd0, 18'd0);

    have = 1'b0;
    cur_w = '0; cur_ip = '0;
    for (int i = 0; i < 600; i++) begin
      if (!have || wait_left == 0) begin
        cur_w = {ops[$urandom_range(0, 5)], 3'($urandom), 3'($urandom), 8'($urandom)};
        if (cur_w[17:14] == OP_WAIT) cur_w[7:0] = 8'($urandom_range(0, 4));
        cur_ip = 18'($urandom);
        have = 1'b1;
        if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = 18'($urandom);
      end
      step($urandom_range(0, 3) != 0, cur_w, cur_ip, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 3'($urandom), 18'($urandom));
    end

    step(0, 18'd0, 18'd0, 0, 0, 3'd0, 18'd0);
    step(0, 18'd0, 18'd0, 0, 0, 3'd0, 18'd0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
